cd_clock_gen: RTL and testbench



---
 rtl/cd_clock_gen_pkg.sv | 9 +
 rtl/cd_clock_gen_div_channel.sv | 41 ++++
 rtl/cd_clock_gen.sv | 76 +++++++
 tb/tb_cd_clock_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cd_clock_gen_pkg.sv
// CD_pkg: channel ids, minimum legal divisor and reset divisors for cd_clock_gen
package CD_pkg;
  typedef enum logic [1:0] {CD_CH_VGA, CD_CH_UART, CD_CH_LM, CD_CH_DB} cd_ch_e;
  localparam int unsigned CD_DIV_MIN = 2;
  localparam int unsigned CD_DEF_VGA = 4;
  localparam int unsigned CD_DEF_UART = 651;
  localparam int unsigned CD_DEF_LM = 50000;
  localparam int unsigned CD_DEF_DB = 10000;
endpackage

// File: rtl/cd_clock_gen_div_channel.sv
// cd_div_channel: one programmable divider with registered square-wave output (tick when CD_TICK_EN)
module cd_div_channel
  import CD_pkg::*;
#(
  parameter int W = 16,
  parameter int unsigned DIV = CD_DEF_VGA
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_div,
  output logic         wrap,
  output logic         clk_out
`ifdef CD_TICK_EN
  ,
  output logic         tick
`endif
);
  logic [W-1:0] cnt;
  logic [W-1:0] div;
  logic         clk_next;
  assign wrap = cnt == div - W'(1);
  assign clk_next = cnt < (div >> 1);
  // a new divisor is only taken at the wrap, so every period is whole
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      div     <= W'(DIV);
      clk_out <= 1'b0;
    end else begin
      cnt     <= wrap ? '0 : cnt + W'(1);
      div     <= (wrap && load) ? load_div : div;
      clk_out <= clk_next;
    end
  end
`ifdef CD_TICK_EN
  always_ff @(posedge clk) begin
    tick <= rst_n && clk_next && !clk_out;
  end
`endif
endmodule

// File: rtl/cd_clock_gen.sv
// cd_clock_gen: four programmable clock dividers with a one-deep config slot; CD_TICK_EN adds tick[3:0]
module cd_clock_gen
  import CD_pkg::*;
#(
  parameter int W = 16,
  parameter int unsigned DIV_VGA = CD_DEF_VGA,
  parameter int unsigned DIV_UART = CD_DEF_UART,
  parameter int unsigned DIV_LM = CD_DEF_LM,
  parameter int unsigned DIV_DB = CD_DEF_DB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [1:0]   cfg_sel,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_err,
  output logic         clk_VGA,
  output logic         clk_UART,
  output logic         clk_LM,
  output logic         clk_DB
`ifdef CD_TICK_EN
  ,
  output logic [3:0]   tick
`endif
);
  logic         pend_vld;
  cd_ch_e       pend_sel;
  logic [W-1:0] pend_div;
  logic [3:0]   wrap;
  logic [3:0]   outs;
  logic [3:0]   load;
  logic         take;
  logic         bad;
  assign cfg_ready = !pend_vld;
  assign take = cfg_valid && cfg_ready;
  assign bad = cfg_div < W'(CD_DIV_MIN);
  genvar i;
  for (i = 0; i < 4; i++) begin : g_ch
    assign load[i] = pend_vld && (pend_sel == 2'(i));
    cd_div_channel #(
      .W(W),
      .DIV(i == 0 ? DIV_VGA : i == 1 ? DIV_UART : i == 2 ? DIV_LM : DIV_DB)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .load(load[i]),
      .load_div(pend_div),
      .wrap(wrap[i]),
      .clk_out(outs[i])
`ifdef CD_TICK_EN
      ,
      .tick(tick[i])
`endif
    );
  end
  assign {clk_DB, clk_LM, clk_UART, clk_VGA} = outs;
  // slot is cleared on the owning channel's wrap; a transfer landing on that same wrap waits for the next one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_sel <= CD_CH_VGA;
      pend_div <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= take && bad;
      if (pend_vld && wrap[pend_sel]) begin
        pend_vld <= 1'b0;
      end else if (take && !bad) begin
        pend_vld <= 1'b1;
        pend_sel <= cd_ch_e'(cfg_sel);
        pend_div <= cfg_div;
      end
    end
  end
endmodule

// File: tb/tb_cd_clock_gen.sv
// tb_cd_clock_gen: table vectors, directed config sequences and random configs against a waveform-queue model
module tb_cd_clock_gen;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [W-1:0] cfg_div = '0;
  logic cfg_ready, cfg_err, clk_VGA, clk_UART, clk_LM, clk_DB;
`ifdef CD_TICK_EN
  logic [3:0] tick;
`endif
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cd_clock_gen dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel),
    .cfg_div(cfg_div),
    .cfg_err(cfg_err),
    .clk_VGA(clk_VGA),
    .clk_UART(clk_UART),
    .clk_LM(clk_LM),
    .clk_DB(clk_DB)
`ifdef CD_TICK_EN
    ,
    .tick(tick)
`endif
  );

  // Reference: each channel replays a queue holding one full period (floor(d/2) ones, then zeros)
  int unsigned defs[4] = '{4, 651, 50000, 10000};
  int unsigned m_div[4];
  bit q[4][$];
  bit m_out[4];
  bit m_tick[4];
  bit m_pend, m_err;
  int m_sel;
  int unsigned m_pdiv;

  task automatic model_edge(input bit r, input bit v, input int s, input int unsigned d);
    bit rdy;
    bit nout;
    rdy = !m_pend;
    if (!r) begin
      for (int c = 0; c < 4; c++) begin
        m_div[c] = defs[c];
        q[c].delete();
        m_out[c] = 0;
        m_tick[c] = 0;
      end
      m_pend = 0;
      m_err = 0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (q[c].size() == 0)
          for (int unsigned k = 0; k < m_div[c]; k++) q[c].push_back(k < m_div[c] / 2);
        nout = q[c].pop_front();
        m_tick[c] = nout && !m_out[c];
        m_out[c] = nout;
        if (q[c].size() == 0 && m_pend && m_sel == c) begin
          m_div[c] = m_pdiv;
          m_pend = 0;
        end
      end
      m_err = v && rdy && d < 2;
      if (v && rdy && d >= 2) begin
        m_pend = 1;
        m_sel = s;
        m_pdiv = d;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [1:0] s, input logic [15:0] d);
    logic [3:0] exp_o;
    rst_n = r;
    cfg_valid = v;
    cfg_sel = s;
    cfg_div = d;
    @(posedge clk);
    model_edge(r, v, int'(s), int'(d));
    #1;
    exp_o = {m_out[3], m_out[2], m_out[1], m_out[0]};
    n_vec++;
    if ({clk_DB, clk_LM, clk_UART, clk_VGA} !== exp_o || cfg_ready !== !m_pend || cfg_err !== m_err) begin
      n_bad++;
      $display("FAIL model t=%0t got clk=%b ready=%b err=%b, expected clk=%b ready=%b err=%b",
               $time, {clk_DB, clk_LM, clk_UART, clk_VGA}, cfg_ready, cfg_err, exp_o, !m_pend, m_err);
    end
`ifdef CD_TICK_EN
    n_vec++;
    if (tick !== {m_tick[3], m_tick[2], m_tick[1], m_tick[0]}) begin
      n_bad++;
      $display("FAIL tick t=%0t got %b expected %b", $time, tick,
               {m_tick[3], m_tick[2], m_tick[1], m_tick[0]});
    end
`endif
  endtask

  task automatic send(input logic [1:0] s, input logic [15:0] d);
    bit done;
    done = 0;
    for (int k = 0; k < 60000 && !done; k++) begin
      done = cfg_ready;
      step(1, 1, s, d);
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout sel=%0d got ready=0 expected ready=1", s);
    end
  endtask

  task automatic wait_ready();
    int k;
    for (k = 0; k < 60000 && !cfg_ready; k++) step(1, 0, 2'd0, 16'd0);
    n_vec++;
    if (!cfg_ready) begin
      n_bad++;
      $display("FAIL ready_timeout got ready=%b expected 1", cfg_ready);
    end
  endtask

  typedef struct {
    bit rst_n, valid;
    bit [1:0] sel;
    bit [15:0] div;
    bit vga, ready, err;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int hi, lo;
    tbl[0] = '{1'b0, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 2'd2, 16'd1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 2'd2, 16'd1, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 2'd2, 16'd0, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 2'd0, 16'd0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 1'b1, 1'b0};
    model_edge(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst_n, tbl[i].valid, tbl[i].sel, tbl[i].div);
      n_vec++;
      if (clk_VGA !== tbl[i].vga || cfg_ready !== tbl[i].ready || cfg_err !== tbl[i].err) begin
        n_bad++;
        $display("FAIL table[%0d] got vga=%b ready=%b err=%b expected vga=%b ready=%b err=%b",
                 i, clk_VGA, cfg_ready, cfg_err, tbl[i].vga, tbl[i].ready, tbl[i].err);
      end
    end
    // UART duty after a fresh reset
    step(0, 0, 2'd0, 16'd0);
    step(0, 0, 2'd0, 16'd0);
    step(1, 0, 2'd0, 16'd0);
    hi = 0;
    lo = 0;
    for (int k = 0; k < 2000 && clk_UART; k++) begin hi++; step(1, 0, 2'd0, 16'd0); end
    for (int k = 0; k < 2000 && !clk_UART; k++) begin lo++; step(1, 0, 2'd0, 16'd0); end
    n_vec++;
    if (hi != 325) begin n_bad++; $display("FAIL uart_high got %0d expected 325", hi); end
    n_vec++;
    if (lo != 326) begin n_bad++; $display("FAIL uart_low got %0d expected 326", lo); end
    // rejected divisor on LM
    step(1, 1, 2'd2, 16'd1);
    n_vec++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reject got err=%b ready=%b expected err=1 ready=1", cfg_err, cfg_ready);
    end
    step(1, 0, 2'd0, 16'd0);
    n_vec++;
    if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse got %b expected 0", cfg_err); end
    // VGA retune to 6
    send(2'd0, 16'd6);
    n_vec++;
    if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL ready_drop got %b expected 0", cfg_ready); end
    wait_ready();
    for (int k = 0; k < 30; k++) step(1, 0, 2'd0, 16'd0);
    // odd divisor on DB, then back-to-back UART and LM
    send(2'd3, 16'd3);
    wait_ready();
    send(2'd1, 16'd5);
    send(2'd2, 16'd7);
    wait_ready();
    for (int k = 0; k < 3000; k++)
      step(1, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 16'($urandom_range(0, 9)));
    // reset while a config is pending
    wait_ready();
    send(2'd0, 16'd9);
    step(0, 0, 2'd0, 16'd0);
    step(0, 0, 2'd0, 16'd0);
    n_vec++;
    if (cfg_ready !== 1'b1 || clk_VGA !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pending got ready=%b vga=%b expected ready=1 vga=0", cfg_ready, clk_VGA);
    end
    for (int k = 0; k < 700; k++) step(1, 0, 2'd0, 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
